// File: rtl/param_counter.sv
// Up/down counter bounded by a runtime max_value, with wrap or saturate at the bounds.
// One-cycle latency from inputs to the count/tc registers; there is no handshake, so a step is taken on every enabled edge.
module param_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_up_bound;
    logic [WIDTH-1:0] w_down_bound;

    assign w_load_clamped = (load_value > max_value) ? max_value : load_value;
    // A count left above a lowered max_value counts as a boundary on the next up-step.
    assign w_up_bound     = SATURATE ? max_value : '0;
    assign w_down_bound   = SATURATE ? '0 : max_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (r_count >= max_value) begin
                    r_count <= w_up_bound;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                    r_tc    <= 1'b0;
                end
            end else begin
                if (r_count == '0) begin
                    r_count <= w_down_bound;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                    r_tc    <= 1'b0;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: boundary mode; 0 = wrap, 1 = hold at bound.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1: reset, synchronous, active-high.
REQ-005 Port en  input  1: count enable; one step per clock while high.
REQ-006 Port up  input  1: direction; 1 = increment, 0 = decrement; sampled only when en=1.
REQ-007 Port load  input  1: synchronous parallel load request.
REQ-008 Port load_value  input  WIDTH: value loaded when load=1.
REQ-009 Port max_value  input  WIDTH: upper count bound (inclusive); count range is 0..max_value.
REQ-010 Port count  output  WIDTH: registered current count.
REQ-011 Port tc  output  1: registered terminal-count pulse.

Function
REQ-012 Priority per clock edge SHALL be reset > load > en; lower-priority requests in the same cycle are ignored.
REQ-013 load=1: count SHALL take min(load_value, max_value) on the next edge; tc SHALL be 0 that cycle.
REQ-014 en=1, up=1, count < max_value: count SHALL become count+1; tc 0.
REQ-015 en=1, up=1, count >= max_value: SATURATE=0 -> count SHALL become 0; SATURATE=1 -> count SHALL become max_value; tc SHALL be 1.
REQ-016 en=1, up=0, count > 0: count SHALL become count-1; tc 0.
REQ-017 en=1, up=0, count = 0: SATURATE=0 -> count SHALL become max_value; SATURATE=1 -> count SHALL stay 0; tc SHALL be 1.
REQ-018 en=0 and load=0: count SHALL hold; tc SHALL be 0.
REQ-019 tc SHALL be registered alongside count, high for exactly the one cycle whose count value results from a boundary step; continued stepping at a saturated bound SHALL re-assert tc every enabled cycle.
REQ-020 max_value SHALL be sampled every cycle; if lowered below current count, the next up-step SHALL be treated as a boundary step (REQ-015) and the next down-step SHALL decrement normally.
REQ-021 max_value = 0: every enabled step SHALL be a boundary step; count stays 0 and tc = 1.
REQ-022 Arithmetic SHALL be unsigned, WIDTH bits, with no carry out beyond WIDTH; max_value = 2^WIDTH-1 SHALL give full-range natural wrap.
REQ-023 Latency: input sampled at edge N SHALL be visible on count/tc after edge N; no combinational path from inputs to outputs.
REQ-024 No internal state other than the count and tc registers.

Reset
REQ-025 reset=1 at a posedge SHALL force count = 0 and tc = 0 regardless of load, en, up.
REQ-026 reset SHALL take effect only at posedge clk; reset pulses between edges SHALL have no effect.
REQ-027 Reset asserted mid-count SHALL abort any pending step; on the first edge after reset deasserts, normal operation per REQ-012..REQ-022 SHALL resume from count 0.

Verification
REQ-028 WIDTH=8, SATURATE=0, max=5, en=1, up=1 from reset -> count 1,2,3,4,5,0,1...; tc=1 only in the cycle count shows 0 after 5.
REQ-029 WIDTH=8, SATURATE=0, max=5, up=0 from count 0 -> count 5,4,3,2,1,0,5; tc=1 in each cycle count becomes 5 via wrap.
REQ-030 SATURATE=1, max=3, up=1 for 6 cycles from 0 -> count 1,2,3,3,3,3; tc=1 on the three held cycles; then up=0 -> 2,1,0,0 with tc=1 on the final 0.
REQ-031 load=1, load_value=200, max=100 while en=1 -> count=100, tc=0; same cycle with reset=1 -> count=0.
REQ-032 Counting at count=9, max lowered 20->4, up=1 -> next count=0 (wrap) with tc=1; with SATURATE=1 -> count=4, tc=1.
REQ-033 WIDTH=8, max=255, count=255, up=1 -> count=0, tc=1; reset pulse between clock edges -> no effect; reset held at edge while en=1 -> count=0, tc=0.
